fetch_decode_stage: RTL

- Instruction fetch unit plus IF/ID pipeline register for the single-issue MIPS-style core.
- Holds the PC and fetches words over a req/ack instruction-memory interface.
- Registers the fetched word and splits it into fields. id_imm[15:0] drives the sign-extension unit directly; rs/rt/rd feed the register file.
- Handles downstream stall and branch/jump redirect (flush).

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/if_id_reg.sv | 51 +++++
 rtl/fetch_decode_stage.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the fetch/decode front end
package cpu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int OPC_MSB   = 31;
    localparam int RS_MSB    = 25;
    localparam int RT_MSB    = 20;
    localparam int RD_MSB    = 15;
    localparam int IMM_MSB   = 15;
    localparam int FUNCT_MSB = 5;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load/hold/flush and field slicing
module if_id_reg
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc_plus4,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc_plus4,
    output logic [5:0]  o_opcode,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_rd,
    output logic [15:0] o_imm,
    output logic [5:0]  o_funct
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;

    // Flush only kills the valid bit; the word itself is left in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= 32'h0000_0000;
        end else if (i_flush) begin
            r_valid    <= 1'b0;
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_instr    <= i_instr;
            r_pc_plus4 <= i_pc_plus4;
        end
    end

    assign o_valid    = r_valid;
    assign o_instr    = r_instr;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_opcode   = r_instr[OPC_MSB -: 6];
    assign o_rs       = r_instr[RS_MSB -: 5];
    assign o_rt       = r_instr[RT_MSB -: 5];
    assign o_rd       = r_instr[RD_MSB -: 5];
    assign o_imm      = r_instr[IMM_MSB -: 16];
    assign o_funct    = r_instr[FUNCT_MSB -: 6];

endmodule

// File: rtl/fetch_decode_stage.sv
// rtl/fetch_decode_stage.sv - PC, fetch FSM and skid buffer in front of the IF/ID register
module fetch_decode_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic [5:0]  id_opcode,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [15:0] id_imm,
    output logic [5:0]  id_funct
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic [31:0]  w_pc_step;
    logic [31:0]  r_skid_instr;
    logic [31:0]  r_skid_pc4;
    logic         w_skid_we;
    logic         w_load;
    logic         w_flush;
    logic [31:0]  w_load_instr;
    logic [31:0]  w_load_pc4;

    assign w_pc_step = r_pc + 32'(PC_STEP);

    // State, PC and skid buffer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc4   <= 32'h0000_0000;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_skid_we) begin
                r_skid_instr <= imem_rdata;
                r_skid_pc4   <= w_pc_step;
            end
        end
    end

    // Next-state, PC update and IF/ID controls; redirect overrides all else.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_skid_we    = 1'b0;
        w_load       = 1'b0;
        w_flush      = 1'b0;
        w_load_instr = imem_rdata;
        w_load_pc4   = w_pc_step;
        if (redirect_valid) begin
            w_flush      = 1'b1;
            w_state_next = S_IDLE;
            w_pc_next    = redirect_target & ~32'h3;
        end else begin
            case (r_state)
                S_IDLE: w_state_next = S_WAIT;
                S_WAIT: begin
                    if (imem_ack) begin
                        if (!stall) begin
                            w_load    = 1'b1;
                            w_pc_next = w_pc_step;
                        end else begin
                            w_skid_we    = 1'b1;
                            w_state_next = S_HOLD;
                        end
                    end else if (!stall) begin
                        w_flush = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        w_load       = 1'b1;
                        w_load_instr = r_skid_instr;
                        w_load_pc4   = r_skid_pc4;
                        w_pc_next    = w_pc_step;
                        w_state_next = S_WAIT;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    assign imem_req  = (r_state == S_WAIT);
    assign imem_addr = r_pc;

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_flush    (w_flush),
        .i_instr    (w_load_instr),
        .i_pc_plus4 (w_load_pc4),
        .o_valid    (id_valid),
        .o_instr    (id_instr),
        .o_pc_plus4 (id_pc_plus4),
        .o_opcode   (id_opcode),
        .o_rs       (id_rs),
        .o_rt       (id_rt),
        .o_rd       (id_rd),
        .o_imm      (id_imm),
        .o_funct    (id_funct)
    );

endmodule
